i2s_frame_sender: RTL and testbench

Parametrised successor to the sound-box I2S sender. Buffers audio frames in a local FIFO and serialises them as I2S or left-justified audio, deriving BCLK/LRCK internally from the master clock. Adds mono/stereo channel modes, mute, underrun detection and a watermark-based audio request. Sits between the packet decoder/sample path and the DAC pins.

---
 rtl/i2s_pkg.sv | 11 +
 rtl/frame_fifo.sv | 54 +++++
 rtl/i2s_frame_sender.sv | 133 +++++++++++++
 tb/tb_i2s_frame_sender.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and helpers for the I2S frame sender and its FIFO.
package i2s_pkg;

  localparam int JUSTIFY_I2S  = 0;
  localparam int JUSTIFY_LEFT = 1;

  function automatic int frame_width(input int channels, input int sample_w);
    return channels * sample_w;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Synchronous frame FIFO; a word pushed this cycle is only readable from the next cycle on.
module frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/i2s_frame_sender.sv
// Buffers audio frames and serialises them as I2S or left-justified audio,
// deriving BCLK and LRCK from the master clock.
module i2s_frame_sender
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W  = 16,
  parameter int CHANNELS  = 2,
  parameter int DEPTH     = 4,
  parameter int BCLK_DIV  = 8,
  parameter int REQ_LEVEL = 1,
  parameter int JUSTIFY   = JUSTIFY_I2S
) (
  input  logic                                     mclk,
  input  logic                                     rst_n,
  input  logic                                     en,
  input  logic                                     mute,
  input  logic                                     in_valid,
  input  logic [frame_width(CHANNELS,SAMPLE_W)-1:0] in_data,
  output logic                                     in_ready,
  output logic [$clog2(DEPTH+1)-1:0]               level,
  output logic                                     audio_req,
  output logic                                     underrun,
  output logic                                     bclk,
  output logic                                     lrck,
  output logic                                     sdata
);

  localparam int FRAME_W   = frame_width(CHANNELS, SAMPLE_W);
  localparam int SLOT_BITS = 2 * SAMPLE_W;
  localparam int IDX_W     = $clog2(SLOT_BITS);
  localparam int DIV_W     = $clog2(BCLK_DIV);
  localparam int LVL_W     = $clog2(DEPTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(BCLK_DIV / 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SLOT_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_RIGHT = IDX_W'(SAMPLE_W);
  localparam logic [LVL_W-1:0] REQ_THR   = LVL_W'(REQ_LEVEL);

  logic [FRAME_W-1:0]   fifo_word;
  logic [SLOT_BITS-1:0] frame_word;
  logic [SLOT_BITS-1:0] load_word;
  logic [SLOT_BITS:0]   shreg;
  logic [SLOT_BITS:0]   shreg_load;
  logic [DIV_W-1:0]     div_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [IDX_W-1:0]     bit_idx_inc;
  logic [LVL_W-1:0]     next_level;
  logic                 strobe;
  logic                 frame_load;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  frame_fifo #(
    .WIDTH(FRAME_W),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (mclk),
    .rst_n  (rst_n),
    .push   (push),
    .pop    (pop),
    .wr_data(in_data),
    .rd_data(fifo_word),
    .level  (level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  generate
    if (CHANNELS == 1) begin : g_mono
      assign frame_word = {fifo_word, fifo_word};
    end else begin : g_stereo
      assign frame_word = fifo_word;
    end
  endgenerate

  assign strobe      = en && (div_cnt == DIV_LAST);
  assign frame_load  = strobe && (bit_idx == IDX_LAST);
  assign push        = in_valid && !fifo_full;
  assign pop         = frame_load && !fifo_empty;
  assign in_ready    = !fifo_full;
  assign bit_idx_inc = bit_idx + 1'b1;
  assign load_word   = (mute || fifo_empty) ? '0 : frame_word;
  assign bclk        = (div_cnt >= DIV_HALF);
  assign sdata       = shreg[SLOT_BITS];

  // The extra top bit carries the previous frame's last bit into the I2S delay slot.
  assign shreg_load = (JUSTIFY == JUSTIFY_LEFT) ? {load_word, 1'b0}
                                                : {shreg[SLOT_BITS-1], load_word};

  always_comb begin
    next_level = level;
    if (push && !pop)      next_level = level + 1'b1;
    else if (pop && !push) next_level = level - 1'b1;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) audio_req <= 1'b1;
    else        audio_req <= (next_level <= REQ_THR);
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_idx  <= IDX_LAST;
      shreg    <= '0;
      lrck     <= 1'b0;
      underrun <= 1'b0;
    end else if (!en) begin
      div_cnt  <= '0;
      bit_idx  <= IDX_LAST;
      shreg    <= '0;
      lrck     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
      if (frame_load) begin
        bit_idx  <= '0;
        lrck     <= 1'b0;
        shreg    <= shreg_load;
        underrun <= fifo_empty;
      end else if (strobe) begin
        bit_idx <= bit_idx_inc;
        lrck    <= (bit_idx_inc >= IDX_RIGHT);
        shreg   <= {shreg[SLOT_BITS-1:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2s_frame_sender.sv
// Directed bench for i2s_frame_sender: stereo I2S, stereo left-justified and mono instances.
module tb_i2s_frame_sender;

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic [2:0]  exp_level;
    logic        exp_ready;
    logic        exp_req;
  } fifo_vec_t;

  logic        mclk;
  logic        rst_n;
  logic        en, mute, in_valid;
  logic [31:0] in_data;
  logic        en_m, mute_m, in_valid_m;
  logic [15:0] in_data_m;

  logic       in_ready_i2s, audio_req_i2s, underrun_i2s, bclk_i2s, lrck_i2s, sdata_i2s;
  logic [2:0] level_i2s;
  logic       in_ready_lj, audio_req_lj, underrun_lj, bclk_lj, lrck_lj, sdata_lj;
  logic [2:0] level_lj;
  logic       in_ready_m, audio_req_m, underrun_m, bclk_m, lrck_m, sdata_m;
  logic [2:0] level_m;

  int checks = 0;
  int passes = 0;

  i2s_frame_sender dut_i2s (
    .mclk(mclk), .rst_n(rst_n), .en(en), .mute(mute), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_i2s), .level(level_i2s),
    .audio_req(audio_req_i2s), .underrun(underrun_i2s), .bclk(bclk_i2s),
    .lrck(lrck_i2s), .sdata(sdata_i2s)
  );

  i2s_frame_sender #(.JUSTIFY(1)) dut_lj (
    .mclk(mclk), .rst_n(rst_n), .en(en), .mute(mute), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready_lj), .level(level_lj),
    .audio_req(audio_req_lj), .underrun(underrun_lj), .bclk(bclk_lj),
    .lrck(lrck_lj), .sdata(sdata_lj)
  );

  i2s_frame_sender #(.CHANNELS(1)) dut_m (
    .mclk(mclk), .rst_n(rst_n), .en(en_m), .mute(mute_m), .in_valid(in_valid_m),
    .in_data(in_data_m), .in_ready(in_ready_m), .level(level_m),
    .audio_req(audio_req_m), .underrun(underrun_m), .bclk(bclk_m),
    .lrck(lrck_m), .sdata(sdata_m)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  task automatic applyStimulus(input fifo_vec_t v);
    in_valid = v.valid;
    in_data  = v.data;
    tick();
  endtask

  // Expected serial pattern indexed by bit_idx, straight from the slot definitions.
  function automatic logic [31:0] exp_serial(input logic [31:0] frame, input logic prev_lsb,
                                             input logic left_just);
    logic [31:0] v;
    for (int k = 0; k < 32; k++) begin
      if (left_just)   v[k] = frame[31-k];
      else if (k == 0) v[k] = prev_lsb;
      else             v[k] = frame[32-k];
    end
    return v;
  endfunction

  // Entered just after a frame load; leaves just after the following load.
  task automatic collect_frame(input logic push_en, input logic [31:0] push_word,
                               output logic [31:0] sd_i2s, output logic [31:0] sd_lj,
                               output logic [31:0] sd_m, output logic [31:0] lr_i2s,
                               output int ur_i2s, output int ur_m);
    sd_i2s = '0; sd_lj = '0; sd_m = '0; lr_i2s = '0;
    ur_i2s = 0;  ur_m = 0;
    for (int c = 0; c < 256; c++) begin
      if (c % 8 == 0) begin
        sd_i2s[c/8] = sdata_i2s;
        sd_lj[c/8]  = sdata_lj;
        sd_m[c/8]   = sdata_m;
        lr_i2s[c/8] = lrck_i2s;
      end
      if (push_en && c == 16) begin
        in_valid = 1'b1;
        in_data  = push_word;
      end
      if (push_en && c == 17) in_valid = 1'b0;
      tick();
      ur_i2s += int'(underrun_i2s);
      ur_m   += int'(underrun_m);
    end
  endtask

  fifo_vec_t   vecs[7];
  logic [31:0] words[4];
  logic [31:0] sd_a, sd_b, sd_c, lr_a;
  int          ur_a, ur_c;
  logic        prev;

  initial begin
    vecs[0] = '{1'b0, 32'h0000_0000, 3'd0, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 32'h1111_1111, 3'd1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 32'h2222_2222, 3'd2, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 32'h3333_3333, 3'd3, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h4444_4444, 3'd4, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 32'h5555_5555, 3'd4, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h0000_0000, 3'd4, 1'b0, 1'b0};
    words   = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};

    rst_n = 1'b0; en = 1'b0; mute = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    en_m = 1'b0; mute_m = 1'b0; in_valid_m = 1'b1; in_data_m = 16'hBEEF;
    ticks(3);
    checkOutput("reset bclk", 32'(bclk_i2s), 32'd0);
    checkOutput("reset lrck", 32'(lrck_i2s), 32'd0);
    checkOutput("reset sdata", 32'(sdata_i2s), 32'd0);
    checkOutput("reset level", 32'(level_i2s), 32'd0);
    checkOutput("reset in_ready", 32'(in_ready_i2s), 32'd1);
    checkOutput("reset audio_req", 32'(audio_req_i2s), 32'd1);
    checkOutput("reset level mono", 32'(level_m), 32'd0);
    rst_n = 1'b1; in_valid = 1'b0; in_valid_m = 1'b0;
    ticks(2);
    checkOutput("post-reset level", 32'(level_i2s), 32'd0);

    // Single stereo frame, I2S and left-justified side by side.
    in_valid = 1'b1; in_data = 32'hA5A5_0F0F;
    tick();
    in_valid = 1'b0;
    checkOutput("push level", 32'(level_i2s), 32'd1);
    en = 1'b1;
    ticks(3);
    checkOutput("bclk low cycle 3", 32'(bclk_i2s), 32'd0);
    tick();
    checkOutput("bclk rise cycle 4", 32'(bclk_i2s), 32'd1);
    ticks(3);
    checkOutput("level before load", 32'(level_i2s), 32'd1);
    tick();
    checkOutput("bclk fall cycle 8", 32'(bclk_i2s), 32'd0);
    checkOutput("load level", 32'(level_i2s), 32'd0);
    checkOutput("load lrck", 32'(lrck_i2s), 32'd0);
    checkOutput("load sdata i2s", 32'(sdata_i2s), 32'd0);
    checkOutput("load sdata lj", 32'(sdata_lj), 32'd1);
    checkOutput("load underrun", 32'(underrun_i2s), 32'd0);
    collect_frame(1'b1, 32'h3C5A_8001, sd_a, sd_b, sd_c, lr_a, ur_a, ur_c);
    checkOutput("frame1 i2s bits", sd_a, exp_serial(32'hA5A5_0F0F, 1'b0, 1'b0));
    checkOutput("frame1 lj bits", sd_b, exp_serial(32'hA5A5_0F0F, 1'b0, 1'b1));
    checkOutput("frame1 lrck", lr_a, 32'hFFFF_0000);
    checkOutput("frame1 underruns", 32'(ur_a), 32'd0);
    checkOutput("frame2 load level", 32'(level_i2s), 32'd0);
    collect_frame(1'b0, 32'h0, sd_a, sd_b, sd_c, lr_a, ur_a, ur_c);
    checkOutput("frame2 i2s bits", sd_a, exp_serial(32'h3C5A_8001, 1'b1, 1'b0));
    checkOutput("frame2 lj bits", sd_b, exp_serial(32'h3C5A_8001, 1'b1, 1'b1));
    checkOutput("frame3 underruns", 32'(ur_a), 32'd1);
    en = 1'b0;
    tick();
    checkOutput("idle bclk", 32'(bclk_i2s), 32'd0);
    checkOutput("idle sdata", 32'(sdata_i2s), 32'd0);
    checkOutput("idle underrun", 32'(underrun_i2s), 32'd0);

    // Underrun from an empty FIFO right after enable.
    ticks(2);
    en = 1'b1;
    ticks(7);
    checkOutput("underrun before load", 32'(underrun_i2s), 32'd0);
    tick();
    checkOutput("underrun at load", 32'(underrun_i2s), 32'd1);
    collect_frame(1'b0, 32'h0, sd_a, sd_b, sd_c, lr_a, ur_a, ur_c);
    checkOutput("underrun frame sdata", sd_a, 32'h0);
    checkOutput("underrun pulse count", 32'(ur_a), 32'd1);
    en = 1'b0;
    tick();

    // FIFO fill, overflow drop and watermark.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d level", i), 32'(level_i2s), 32'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready_i2s), 32'(vecs[i].exp_ready));
      checkOutput($sformatf("vec%0d audio_req", i), 32'(audio_req_i2s), 32'(vecs[i].exp_req));
    end
    en = 1'b1;
    ticks(8);
    checkOutput("drain load level", 32'(level_i2s), 32'd3);
    checkOutput("drain load audio_req", 32'(audio_req_i2s), 32'd0);
    prev = 1'b0;
    for (int f = 0; f < 4; f++) begin
      collect_frame(1'b0, 32'h0, sd_a, sd_b, sd_c, lr_a, ur_a, ur_c);
      checkOutput($sformatf("drain%0d i2s bits", f), sd_a, exp_serial(words[f], prev, 1'b0));
      checkOutput($sformatf("drain%0d lj bits", f), sd_b, exp_serial(words[f], prev, 1'b1));
      checkOutput($sformatf("drain%0d level", f), 32'(level_i2s), (f < 3) ? 32'(2 - f) : 32'd0);
      checkOutput($sformatf("drain%0d audio_req", f), 32'(audio_req_i2s), (f == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("drain%0d underruns", f), 32'(ur_a), (f == 3) ? 32'd1 : 32'd0);
      prev = words[f][0];
    end
    en = 1'b0;
    tick();

    // Enable dropped mid-frame: idle outputs, no pop until the next load.
    in_valid = 1'b1; in_data = 32'h6666_6666;
    tick();
    in_valid = 1'b0;
    en = 1'b1;
    ticks(8);
    checkOutput("abort first load level", 32'(level_i2s), 32'd0);
    in_valid = 1'b1; in_data = 32'h7777_7777;
    tick();
    in_valid = 1'b0;
    ticks(20);
    en = 1'b0;
    tick();
    checkOutput("abort bclk", 32'(bclk_i2s), 32'd0);
    checkOutput("abort lrck", 32'(lrck_i2s), 32'd0);
    checkOutput("abort sdata", 32'(sdata_i2s), 32'd0);
    checkOutput("abort level held", 32'(level_i2s), 32'd1);
    ticks(3);
    en = 1'b1;
    ticks(7);
    checkOutput("restart pre-load level", 32'(level_i2s), 32'd1);
    tick();
    checkOutput("restart load level", 32'(level_i2s), 32'd0);
    checkOutput("restart underrun", 32'(underrun_i2s), 32'd0);
    en = 1'b0;
    tick();

    // Mono: sample on both slots, then a muted load that still pops.
    in_valid_m = 1'b1; in_data_m = 16'h8001;
    ticks(2);
    in_valid_m = 1'b0;
    checkOutput("mono level", 32'(level_m), 32'd2);
    checkOutput("mono audio_req", 32'(audio_req_m), 32'd0);
    en_m = 1'b1;
    ticks(8);
    checkOutput("mono load level", 32'(level_m), 32'd1);
    mute_m = 1'b1;
    collect_frame(1'b0, 32'h0, sd_a, sd_b, sd_c, lr_a, ur_a, ur_c);
    checkOutput("mono frame bits", sd_c, exp_serial(32'h8001_8001, 1'b0, 1'b0));
    checkOutput("mono underruns", 32'(ur_c), 32'd0);
    checkOutput("mono muted pop level", 32'(level_m), 32'd0);
    mute_m = 1'b0;
    collect_frame(1'b0, 32'h0, sd_a, sd_b, sd_c, lr_a, ur_a, ur_c);
    checkOutput("mono muted bits", sd_c, exp_serial(32'h0, 1'b1, 1'b0));
    checkOutput("mono empty underruns", 32'(ur_c), 32'd1);
    en_m = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
